wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback (A) and the

---
 rtl/proc_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 70 +++++++
 rtl/wb_port_arbiter.sv | 119 +++++++++++
 tb/tb_wb_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types for the writeback-port arbiter slice.
//   DATA_W / ADDR_W : register data and address widths
//   wb_entry_t      : buffered mult/div result {kill, rd, data}
//   arb_state_e     : arbiter FSM states
package proc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef struct packed {
    logic              kill;  // entry must retire without writing
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    S_NORM,
    S_STALL
  } arb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of mult/div results awaiting the register-file write port.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   push, push_entry     store an entry (caller guarantees not full)
//   pop                  drop the head (caller guarantees not empty)
//   kill_en, kill_rd     mark every stored entry with rd==kill_rd as killed
//   head                 oldest entry
//   count, full, empty   occupancy
module wb_fifo
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  input  logic             kill_en,
  input  logic [ADDR_W-1:0] kill_rd,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  wb_entry_t        mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (kill_en) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (mem_q[i].rd == kill_rd) begin
            mem_q[i].kill <= 1'b1;
          end
        end
      end
      // Placed after the kill loop so an entry pushed this cycle is never killed.
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (A, priority) and the
// multi-cycle mult/div unit (B, buffered). A head that waits MAX_WAIT cycles forces a
// one-cycle pipeline stall so it can drain. A writes kill buffered B results to the same rd.
// Ports:
//   a_valid/a_regwrite/a_rd/a_data  pipeline writeback request
//   b_valid/b_ready/b_rd/b_data     mult/div result handshake
//   rf_we/rf_waddr/rf_wdata         registered register-file write
//   stall_pipe                      registered pipeline freeze
//   fifo_count                      buffered B entries
module wb_port_arbiter
  import proc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4,
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic              a_regwrite,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_pipe,
  output logic [CNT_W-1:0]  fifo_count
);

  wb_entry_t         head, push_entry;
  logic              full, empty, push, pop;
  logic              a_req, head_live, grant_a, grant_b;
  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign a_req      = a_valid & a_regwrite & (a_rd != '0);
  assign b_ready    = ~full;
  assign push       = b_valid & ~full;
  // Writes to $0 are stored pre-killed so they retire in order without a write.
  assign push_entry = '{kill: (b_rd == '0), rd: b_rd, data: b_data};
  assign head_live  = ~empty & ~head.kill;

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .kill_en   (grant_a),
    .kill_rd   (a_rd),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_NORM: begin
        grant_a = a_req;
        grant_b = head_live & ~a_req;
        // A killed head retires even while A owns the port.
        pop     = grant_b | (~empty & head.kill);
        if (pop) begin
          wait_d = '0;
        end else if (head_live) begin
          wait_d = wait_q + 1'b1;
        end
        if (wait_d == WAIT_W'(MAX_WAIT)) begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        // A is frozen and will be re-presented; the head gets the port.
        grant_b = head_live;
        pop     = ~empty;
        wait_d  = '0;
        state_d = S_NORM;
      end
      default: state_d = S_NORM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_NORM;
      wait_q   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rf_we   <= grant_a | grant_b;
      if (grant_a) begin
        rf_waddr <= a_rd;
        rf_wdata <= a_data;
      end else if (grant_b) begin
        rf_waddr <= head.rd;
        rf_wdata <= head.data;
      end
    end
  end

  assign stall_pipe = (state_q == S_STALL);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_regwrite, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata;
  logic        rf_we, stall_pipe;
  logic [1:0]  fifo_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .MAX_WAIT  (MAXW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_regwrite(a_regwrite),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_pipe(stall_pipe),
    .fifo_count(fifo_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending B results plus "stall next cycle" and a wait tally.
  typedef struct {
    bit          kill;
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  bit          m_stall;
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_stall = 0;
      m_wait  = 0;
      m_we    = 0;
      m_addr  = '0;
      m_data  = '0;
      chk("rst_we", rf_we, 0);
      chk("rst_stall", stall_pipe, 0);
      chk("rst_count", fifo_count, 0);
    end else begin
      bit    a_req, push, pop, ga, gb, nstall;
      ment_t e;
      chk("rf_we", rf_we, m_we);
      chk("rf_waddr", rf_waddr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
      chk("stall_pipe", stall_pipe, m_stall);
      chk("fifo_count", fifo_count, mq.size());
      chk("b_ready", b_ready, mq.size() < DEPTH);

      a_req  = a_valid && a_regwrite && (a_rd != 0);
      push   = b_valid && (mq.size() < DEPTH);
      ga     = 0;
      gb     = 0;
      pop    = 0;
      nstall = 0;
      if (m_stall) begin
        if (mq.size() > 0) begin
          pop = 1;
          gb  = !mq[0].kill;
        end
        m_wait = 0;
      end else begin
        ga = a_req;
        if (mq.size() > 0) begin
          if (mq[0].kill) pop = 1;
          else if (!a_req) begin
            pop = 1;
            gb  = 1;
          end
        end
        if (pop) m_wait = 0;
        else if (mq.size() > 0 && !mq[0].kill) m_wait++;
        nstall = (m_wait == MAXW);
      end

      m_we = ga || gb;
      if (ga) begin
        m_addr = a_rd;
        m_data = a_data;
      end else if (gb) begin
        m_addr = mq[0].rd;
        m_data = mq[0].data;
      end
      if (ga) begin
        foreach (mq[i]) if (mq[i].rd == a_rd) mq[i].kill = 1;
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.kill = (b_rd == 0);
        e.rd   = b_rd;
        e.data = b_data;
        mq.push_back(e);
      end
      m_stall = nstall;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] d);
    a_valid    = v;
    a_regwrite = rw;
    a_rd       = rd;
    a_data     = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
    b_valid = v;
    b_rd    = rd;
    b_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_b(0, 0, 0);
    // 1: reset with A pending, then first A write
    set_a(1, 1, 8, 32'h11);
    tick();
    tick();
    chk("t1_rst_we", rf_we, 0);
    chk("t1_rst_stall", stall_pipe, 0);
    rst_n = 1'b1;
    tick();
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 8);
    chk("t1_wdata", rf_wdata, 32'h11);
    set_a(0, 0, 0, 0);
    tick();

    // 2: lone B result
    set_b(1, 3, 32'hAB);
    tick();
    set_b(0, 0, 0);
    tick();
    chk("t2_we", rf_we, 1);
    chk("t2_waddr", rf_waddr, 3);
    chk("t2_wdata", rf_wdata, 32'hAB);
    tick();

    // 3: starved B forces a stall
    set_a(1, 1, 9, 32'h100);
    set_b(1, 5, 32'h55);
    tick();
    set_b(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_nostall", stall_pipe, 0);
    end
    tick();
    chk("t3_stall", stall_pipe, 1);
    tick();
    chk("t3_b_we", rf_we, 1);
    chk("t3_b_waddr", rf_waddr, 5);
    chk("t3_b_wdata", rf_wdata, 32'h55);
    chk("t3_stall_drop", stall_pipe, 0);
    tick();
    chk("t3_a_we", rf_we, 1);
    chk("t3_a_waddr", rf_waddr, 9);
    set_a(0, 0, 0, 0);
    tick();

    // 4: full buffer back-pressure
    set_a(1, 1, 10, 32'hA0);
    set_b(1, 1, 32'h1);
    tick();
    set_b(1, 2, 32'h2);
    tick();
    chk("t4_ready_full", b_ready, 0);
    chk("t4_count2", fifo_count, 2);
    set_b(1, 4, 32'h4);
    tick();
    chk("t4_count_hold", fifo_count, 2);
    set_a(0, 0, 0, 0);
    tick();
    chk("t4_no_same_push", fifo_count, 1);
    chk("t4_pop1", rf_waddr, 1);
    tick();
    chk("t4_push_after", fifo_count, 1);
    chk("t4_pop2", rf_waddr, 2);
    set_b(0, 0, 0);
    tick();
    chk("t4_pop4", rf_waddr, 4);
    chk("t4_empty", fifo_count, 0);
    tick();

    // 5: WAW cancel
    set_a(1, 1, 11, 32'hB0);
    set_b(1, 7, 32'h1);
    tick();
    set_b(0, 0, 0);
    set_a(1, 1, 7, 32'h2);
    tick();
    chk("t5_we", rf_we, 1);
    chk("t5_waddr", rf_waddr, 7);
    chk("t5_wdata", rf_wdata, 32'h2);
    set_a(0, 0, 0, 0);
    tick();
    chk("t5_kill_we", rf_we, 0);
    chk("t5_kill_cnt", fifo_count, 0);
    tick();

    // 6: $0 destinations
    set_a(1, 1, 0, 32'hC0);
    set_b(1, 0, 32'hC1);
    tick();
    chk("t6_we0", rf_we, 0);
    set_b(0, 0, 0);
    tick();
    chk("t6_we1", rf_we, 0);
    chk("t6_cnt", fifo_count, 0);
    set_b(1, 6, 32'h6);
    tick();
    set_b(0, 0, 0);
    tick();
    chk("t6_b_we", rf_we, 1);
    chk("t6_b_waddr", rf_waddr, 6);
    set_a(0, 0, 0, 0);
    tick();

    // 7: reset during stall
    set_a(1, 1, 12, 32'hD0);
    set_b(1, 13, 32'hD1);
    tick();
    set_b(1, 14, 32'hD2);
    tick();
    set_b(0, 0, 0);
    tick();
    tick();
    tick();
    chk("t7_stall", stall_pipe, 1);
    chk("t7_cnt2", fifo_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_stall", stall_pipe, 0);
    chk("t7_rst_cnt", fifo_count, 0);
    chk("t7_rst_we", rf_we, 0);
    set_a(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic, small rd range for frequent collisions
    for (int i = 0; i < 3000; i++) begin
      set_a($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom);
      set_b($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
